// File: rtl/backprop_stack_ctrl.sv
// Control sequencer for backprop_stack: walks layers from last to 0, issuing the
// storage strobe, the dy/dy_old chain strobe, then every dc/dw row under valid/ready.
module backprop_stack_ctrl #(
  parameter int max_layer_size = 4,
  parameter int size           = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] num_layers,
  input  logic        stream_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        update_storage,
  output logic [31:0] current_layer,
  output logic        update_dy_dy_old,
  output logic        cal_dc_dw,
  output logic [31:0] dc_dw_layer,
  output logic [31:0] dc_dw_row,
  output logic        dc_dw_valid
);

  localparam logic [31:0] MAX_L    = 32'(max_layer_size);
  localparam logic [31:0] LAST_ROW = 32'(size - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_CHAIN,
    S_STREAM,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] layer_q, layer_d;
  logic [31:0] row_q, row_d;
  logic        err_q, err_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        update_storage_q, update_storage_d;
  logic        update_dy_dy_old_q, update_dy_dy_old_d;
  logic        cal_dc_dw_q, cal_dc_dw_d;
  logic        dc_dw_valid_q, dc_dw_valid_d;
  logic [31:0] current_layer_q, current_layer_d;
  logic [31:0] dc_dw_layer_q, dc_dw_layer_d;
  logic [31:0] dc_dw_row_q, dc_dw_row_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; counters are bounded by the transitions, never by wrap.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    row_d   = row_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((num_layers == 32'd0) || (num_layers > MAX_L)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            layer_d = num_layers - 32'd1;
            state_d = S_STORE;
          end
        end
      end
      S_STORE: state_d = S_CHAIN;
      S_CHAIN: begin
        row_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (stream_ready) begin
          if (row_q == LAST_ROW) begin
            if (layer_q == 32'd0) begin
              state_d = S_DONE;
            end else begin
              layer_d = layer_q - 32'd1;
              state_d = S_STORE;
            end
          end else begin
            row_d = row_q + 32'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    busy_d             = (state_d != S_IDLE);
    done_d             = (state_d == S_DONE);
    error_d            = (state_d == S_DONE) && err_d;
    update_storage_d   = (state_d == S_STORE);
    update_dy_dy_old_d = (state_d == S_CHAIN);
    cal_dc_dw_d        = (state_d == S_STREAM);
    dc_dw_valid_d      = (state_d == S_STREAM);
    current_layer_d    = current_layer_q;
    dc_dw_layer_d      = dc_dw_layer_q;
    dc_dw_row_d        = dc_dw_row_q;
    if ((state_d == S_STORE) || (state_d == S_CHAIN) || (state_d == S_STREAM)) begin
      current_layer_d = layer_d;
    end
    if (state_d == S_STREAM) begin
      dc_dw_layer_d = layer_d;
      dc_dw_row_d   = row_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      error_q            <= 1'b0;
      update_storage_q   <= 1'b0;
      update_dy_dy_old_q <= 1'b0;
      cal_dc_dw_q        <= 1'b0;
      dc_dw_valid_q      <= 1'b0;
      current_layer_q    <= '0;
      dc_dw_layer_q      <= '0;
      dc_dw_row_q        <= '0;
    end else begin
      busy_q             <= busy_d;
      done_q             <= done_d;
      error_q            <= error_d;
      update_storage_q   <= update_storage_d;
      update_dy_dy_old_q <= update_dy_dy_old_d;
      cal_dc_dw_q        <= cal_dc_dw_d;
      dc_dw_valid_q      <= dc_dw_valid_d;
      current_layer_q    <= current_layer_d;
      dc_dw_layer_q      <= dc_dw_layer_d;
      dc_dw_row_q        <= dc_dw_row_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign update_storage   = update_storage_q;
  assign update_dy_dy_old = update_dy_dy_old_q;
  assign cal_dc_dw        = cal_dc_dw_q;
  assign dc_dw_valid      = dc_dw_valid_q;
  assign current_layer    = current_layer_q;
  assign dc_dw_layer      = dc_dw_layer_q;
  assign dc_dw_row        = dc_dw_row_q;

endmodule
